// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks E/M/W writers by tnew and
// derives stall plus D- and E-stage forwarding selects.
module hazard_scoreboard (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic       d_regwrite,
  input  logic [4:0] d_wa,
  input  logic [1:0] d_tnew,
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e
);

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic [4:0] wa;
    logic [1:0] tnew;
  } ent_t;

  localparam logic [1:0] SEL_RF = 2'd0;
  localparam logic [1:0] SEL_E  = 2'd1;
  localparam logic [1:0] SEL_M  = 2'd2;
  localparam logic [1:0] SEL_W  = 2'd3;
  localparam logic [1:0] TU_NONE = 2'd3;

  ent_t       e_q, m_q, w_q;
  ent_t       e_d, m_d, w_d;
  logic [4:0] e_rs_q, e_rt_q;
  logic [4:0] e_rs_d, e_rt_d;

  logic       stall_c;
  logic [1:0] frs_d_c, frt_d_c;
  logic [1:0] frs_e_c, frt_e_c;

  // register 0 is hardwired, so it can never be a hazard
  function automatic logic hit(
    input ent_t       en,
    input logic [4:0] r
  );
    return en.valid && en.regwrite &&
           (en.wa == r) && (r != 5'd0);
  endfunction

  function automatic ent_t age(input ent_t en);
    ent_t o;
    o = en;
    if (en.tnew != 2'd0)
      o.tnew = en.tnew - 2'd1;
    return o;
  endfunction

  // youngest match governs; older ones are shadowed
  function automatic logic op_stall(
    input ent_t       e,
    input ent_t       m,
    input ent_t       w,
    input logic [4:0] r,
    input logic [1:0] tuse
  );
    logic s;
    s = 1'b0;
    if (tuse != TU_NONE) begin
      if (hit(e, r))
        s = e.tnew > tuse;
      else if (hit(m, r))
        s = m.tnew > tuse;
      else if (hit(w, r))
        s = w.tnew > tuse;
    end
    return s;
  endfunction

  function automatic logic [1:0] sel_d(
    input ent_t       e,
    input ent_t       m,
    input ent_t       w,
    input logic [4:0] r
  );
    logic [1:0] s;
    s = SEL_RF;
    if (hit(e, r))
      s = (e.tnew == 2'd0) ? SEL_E : SEL_RF;
    else if (hit(m, r))
      s = (m.tnew == 2'd0) ? SEL_M : SEL_RF;
    else if (hit(w, r))
      s = (w.tnew == 2'd0) ? SEL_W : SEL_RF;
    return s;
  endfunction

  function automatic logic [1:0] sel_e(
    input ent_t       m,
    input ent_t       w,
    input logic [4:0] r
  );
    logic [1:0] s;
    s = SEL_RF;
    if (hit(m, r))
      s = (m.tnew == 2'd0) ? SEL_M : SEL_RF;
    else if (hit(w, r))
      s = (w.tnew == 2'd0) ? SEL_W : SEL_RF;
    return s;
  endfunction

  // hazard detection and forwarding selects
  always_comb begin
    stall_c = d_valid &&
      (op_stall(e_q, m_q, w_q, d_rs, d_tuse_rs) ||
       op_stall(e_q, m_q, w_q, d_rt, d_tuse_rt));
    frs_d_c = sel_d(e_q, m_q, w_q, d_rs);
    frt_d_c = sel_d(e_q, m_q, w_q, d_rt);
    frs_e_c = SEL_RF;
    frt_e_c = SEL_RF;
    if (e_q.valid) begin
      frs_e_c = sel_e(m_q, w_q, e_rs_q);
      frt_e_c = sel_e(m_q, w_q, e_rt_q);
    end
  end

  // outputs are forced quiet while reset is held
  always_comb begin
    stall    = reset_n && stall_c;
    fwd_rs_d = reset_n ? frs_d_c : SEL_RF;
    fwd_rt_d = reset_n ? frt_d_c : SEL_RF;
    fwd_rs_e = reset_n ? frs_e_c : SEL_RF;
    fwd_rt_e = reset_n ? frt_e_c : SEL_RF;
  end

  // pipeline advance: stall injects a bubble into E
  always_comb begin
    m_d    = age(e_q);
    w_d    = age(m_q);
    e_d    = '0;
    e_rs_d = 5'd0;
    e_rt_d = 5'd0;
    if (!stall_c) begin
      e_d.valid    = d_valid;
      e_d.regwrite = d_regwrite;
      e_d.wa       = d_wa;
      e_d.tnew     = d_tnew;
      e_rs_d       = d_rs;
      e_rt_d       = d_rt;
    end
  end

  // entry registers with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q    <= '0;
      m_q    <= '0;
      w_q    <= '0;
      e_rs_q <= 5'd0;
      e_rt_q <= 5'd0;
    end else begin
      e_q    <= e_d;
      m_q    <= m_d;
      w_q    <= w_d;
      e_rs_q <= e_rs_d;
      e_rt_q <= e_rt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expected
// outputs are queued with each stimulus and popped on sample.
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset_n;
  logic       d_valid;
  logic [4:0] d_rs, d_rt;
  logic [1:0] d_tuse_rs, d_tuse_rt;
  logic       d_regwrite;
  logic [4:0] d_wa;
  logic [1:0] d_tnew;
  logic       stall;
  logic [1:0] fwd_rs_d, fwd_rt_d;
  logic [1:0] fwd_rs_e, fwd_rt_e;

  typedef struct packed {
    logic       st;
    logic [1:0] rsd;
    logic [1:0] rtd;
    logic [1:0] rse;
    logic [1:0] rte;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  hazard_scoreboard dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .d_valid    (d_valid),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_regwrite (d_regwrite),
    .d_wa       (d_wa),
    .d_tnew     (d_tnew),
    .stall      (stall),
    .fwd_rs_d   (fwd_rs_d),
    .fwd_rt_d   (fwd_rt_d),
    .fwd_rs_e   (fwd_rs_e),
    .fwd_rt_e   (fwd_rt_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic setd(
    input logic       v,
    input logic [4:0] rs,
    input logic [1:0] tus,
    input logic [4:0] rt,
    input logic [1:0] tut,
    input logic       rw,
    input logic [4:0] wa,
    input logic [1:0] tn
  );
    d_valid    = v;
    d_rs       = rs;
    d_tuse_rs  = tus;
    d_rt       = rt;
    d_tuse_rt  = tut;
    d_regwrite = rw;
    d_wa       = wa;
    d_tnew     = tn;
  endtask

  task automatic bubble();
    setd(1'b0, 5'd0, 2'd3, 5'd0, 2'd3,
         1'b0, 5'd0, 2'd0);
  endtask

  task automatic expect_o(
    input logic       st,
    input logic [1:0] rsd,
    input logic [1:0] rtd,
    input logic [1:0] rse,
    input logic [1:0] rte
  );
    exp_t x;
    x.st  = st;
    x.rsd = rsd;
    x.rtd = rtd;
    x.rse = rse;
    x.rte = rte;
    q.push_back(x);
  endtask

  task automatic check(input string tag);
    exp_t x;
    #1;
    checks++;
    assert (q.size() > 0) else begin
      errors++;
      $error("FAIL %s queue got 0 exp 1", tag);
    end
    if (q.size() > 0) begin
      x = q.pop_front();
      checks++;
      assert (stall === x.st) else begin
        errors++;
        $error("FAIL %s stall got %0d exp %0d",
               tag, stall, x.st);
      end
      checks++;
      assert (fwd_rs_d === x.rsd) else begin
        errors++;
        $error("FAIL %s fwd_rs_d got %0d exp %0d",
               tag, fwd_rs_d, x.rsd);
      end
      checks++;
      assert (fwd_rt_d === x.rtd) else begin
        errors++;
        $error("FAIL %s fwd_rt_d got %0d exp %0d",
               tag, fwd_rt_d, x.rtd);
      end
      checks++;
      assert (fwd_rs_e === x.rse) else begin
        errors++;
        $error("FAIL %s fwd_rs_e got %0d exp %0d",
               tag, fwd_rs_e, x.rse);
      end
      checks++;
      assert (fwd_rt_e === x.rte) else begin
        errors++;
        $error("FAIL %s fwd_rt_e got %0d exp %0d",
               tag, fwd_rt_e, x.rte);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    setd(1'b1, 5'd8, 2'd0, 5'd8, 2'd0,
         1'b1, 5'd8, 2'd2);
    expect_o(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    check("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // load-use: lw $8 then add $8
    setd(1'b1, 5'd1, 2'd1, 5'd0, 2'd3,
         1'b1, 5'd8, 2'd2);
    expect_o(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    check("lw8");
    @(negedge clk);
    setd(1'b1, 5'd8, 2'd1, 5'd9, 2'd1,
         1'b1, 5'd10, 2'd1);
    expect_o(1'b1, 2'd0, 2'd0, 2'd0, 2'd0);
    check("lu_stall");
    @(negedge clk);
    expect_o(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    check("lu_release");
    @(negedge clk);
    bubble();
    expect_o(1'b0, 2'd0, 2'd0, 2'd3, 2'd0);
    check("lu_fwd_e_w");

    // ALU result to branch
    @(negedge clk);
    setd(1'b1, 5'd0, 2'd3, 5'd0, 2'd3,
         1'b1, 5'd5, 2'd1);
    expect_o(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    check("ori5");
    @(negedge clk);
    setd(1'b1, 5'd5, 2'd0, 5'd5, 2'd0,
         1'b0, 5'd0, 2'd0);
    expect_o(1'b1, 2'd0, 2'd0, 2'd0, 2'd0);
    check("br_stall");
    @(negedge clk);
    expect_o(1'b0, 2'd2, 2'd2, 2'd0, 2'd0);
    check("br_fwd_m");

    // jal then jr $31
    @(negedge clk);
    setd(1'b1, 5'd0, 2'd3, 5'd0, 2'd3,
         1'b1, 5'd31, 2'd0);
    expect_o(1'b0, 2'd0, 2'd0, 2'd3, 2'd3);
    check("jal_br_fwd_e");
    @(negedge clk);
    setd(1'b1, 5'd31, 2'd0, 5'd0, 2'd3,
         1'b0, 5'd0, 2'd0);
    expect_o(1'b0, 2'd1, 2'd0, 2'd0, 2'd0);
    check("jr_fwd_e");

    // shadowing: ori $9 then lw $9 then add $9
    @(negedge clk);
    setd(1'b1, 5'd0, 2'd3, 5'd0, 2'd3,
         1'b1, 5'd9, 2'd1);
    expect_o(1'b0, 2'd0, 2'd0, 2'd2, 2'd0);
    check("ori9_jr_fwd_m");
    @(negedge clk);
    setd(1'b1, 5'd0, 2'd3, 5'd0, 2'd3,
         1'b1, 5'd9, 2'd2);
    expect_o(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    check("lw9");
    @(negedge clk);
    setd(1'b1, 5'd9, 2'd1, 5'd9, 2'd1,
         1'b1, 5'd12, 2'd1);
    expect_o(1'b1, 2'd0, 2'd0, 2'd0, 2'd0);
    check("shadow_stall");
    @(negedge clk);
    expect_o(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    check("shadow_m_over_w");
    @(negedge clk);
    bubble();
    expect_o(1'b0, 2'd0, 2'd0, 2'd3, 2'd3);
    check("shadow_fwd_e");

    // register 0 never matches
    @(negedge clk);
    setd(1'b1, 5'd0, 2'd3, 5'd0, 2'd3,
         1'b1, 5'd0, 2'd2);
    expect_o(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    check("lw0");
    @(negedge clk);
    setd(1'b1, 5'd0, 2'd1, 5'd0, 2'd0,
         1'b1, 5'd13, 2'd1);
    expect_o(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    check("r0_use");
    @(negedge clk);
    bubble();
    expect_o(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    check("r0_bubble");

    // invalid D slot never stalls
    @(negedge clk);
    setd(1'b1, 5'd0, 2'd3, 5'd0, 2'd3,
         1'b1, 5'd14, 2'd2);
    expect_o(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    check("lw14");
    @(negedge clk);
    setd(1'b0, 5'd14, 2'd0, 5'd14, 2'd0,
         1'b0, 5'd0, 2'd0);
    expect_o(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    check("invalid_d");

    // reset while stalled
    @(negedge clk);
    setd(1'b1, 5'd14, 2'd0, 5'd0, 2'd3,
         1'b1, 5'd15, 2'd1);
    expect_o(1'b1, 2'd0, 2'd0, 2'd0, 2'd0);
    check("pre_reset_stall");
    #2;
    reset_n = 1'b0;
    expect_o(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    check("reset_mid_stall");
    @(negedge clk);
    reset_n = 1'b1;
    expect_o(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    check("post_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bubble();
      expect_o(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
      check($sformatf("post_bubble%0d", i));
    end

    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain got %0d exp 0",
             q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
